// File: rtl/sweep_stim_gen_pkg.sv
// rtl/sweep_stim_gen_pkg.sv - shared state encoding, mode codes and signature constants
package sweep_stim_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] MODE_BIN_UP   = 2'd0;
  localparam logic [1:0] MODE_GRAY     = 2'd1;
  localparam logic [1:0] MODE_WALK1    = 2'd2;
  localparam logic [1:0] MODE_BIN_DOWN = 2'd3;

  localparam logic [15:0] SIG_SEED = 16'hFFFF;
  localparam logic [15:0] SIG_POLY = 16'h1021;

  // One CRC-16/CCITT style shift with the sampled result folded into bit 0.
  function automatic logic [15:0] sig_next(input logic [15:0] sig, input logic bit_in);
    logic [15:0] nxt;
    nxt = {sig[14:0], 1'b0} ^ (sig[15] ? SIG_POLY : 16'h0000);
    nxt[0] = nxt[0] ^ bit_in;
    return nxt;
  endfunction

endpackage

// File: rtl/sweep_pattern_map.sv
// rtl/sweep_pattern_map.sv - combinational map from (mode, index) to switch pattern
module sweep_pattern_map
  import sweep_stim_gen_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] idx,
  output logic [WIDTH-1:0] pattern
);

  always_comb begin
    pattern = idx;
    case (mode)
      MODE_BIN_UP:   pattern = idx;
      MODE_GRAY:     pattern = idx ^ (idx >> 1);
      MODE_WALK1:    pattern = {{(WIDTH-1){1'b0}}, 1'b1} << idx;
      MODE_BIN_DOWN: pattern = ~idx;
      default:       pattern = idx;
    endcase
  end

endmodule

// File: rtl/sweep_stim_gen.sv
// rtl/sweep_stim_gen.sv - pattern sweep sequencer with hold windows and result ones count
// Optional SWEEP_STIM_SIGNATURE_EN adds a 16-bit CRC signature of the sampled results.
module sweep_stim_gen
  import sweep_stim_gen_pkg::*;
#(
  parameter int WIDTH       = 5,
  parameter int HOLD_CYCLES = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       mode,
  input  logic             result,
  output logic [WIDTH-1:0] sw,
  output logic             pat_valid,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   ones_count
`ifdef SWEEP_STIM_SIGNATURE_EN
  ,
  output logic [15:0]      signature
`endif
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0]  HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [WIDTH:0] LAST_FULL = (WIDTH+1)'((1 << WIDTH) - 1);
  localparam logic [WIDTH:0] LAST_WALK = (WIDTH+1)'(WIDTH - 1);

  state_t           state, state_nx;
  logic [WIDTH:0]   idx, idx_nx;
  logic [HW-1:0]    hold_cnt, hold_nx;
  logic [1:0]       mode_r, mode_nx;
  logic [WIDTH-1:0] sw_nx;
  logic             pv_nx;
  logic [WIDTH:0]   ones_nx;
  logic [1:0]       map_mode;
  logic [WIDTH-1:0] map_idx;
  logic [WIDTH-1:0] map_pat;
  logic             at_last;
`ifdef SWEEP_STIM_SIGNATURE_EN
  logic [15:0]      sig_nx;
`endif

  // In RUN the map looks one pattern ahead; otherwise it prepares pattern 0 for a start.
  assign map_mode = (state == ST_RUN) ? mode_r : mode;
  assign map_idx  = (state == ST_RUN) ? (idx[WIDTH-1:0] + WIDTH'(1)) : '0;
  assign at_last  = (mode_r == MODE_WALK1) ? (idx == LAST_WALK) : (idx == LAST_FULL);

  sweep_pattern_map #(.WIDTH(WIDTH)) u_map (
    .mode    (map_mode),
    .idx     (map_idx),
    .pattern (map_pat)
  );

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    hold_nx  = hold_cnt;
    mode_nx  = mode_r;
    sw_nx    = sw;
    pv_nx    = 1'b0;
    ones_nx  = ones_count;
`ifdef SWEEP_STIM_SIGNATURE_EN
    sig_nx   = signature;
`endif
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_nx = ST_RUN;
          mode_nx  = mode;
          idx_nx   = '0;
          hold_nx  = '0;
          ones_nx  = '0;
          sw_nx    = map_pat;
          pv_nx    = 1'b1;
`ifdef SWEEP_STIM_SIGNATURE_EN
          sig_nx   = SIG_SEED;
`endif
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_nx = ST_IDLE;
        end else if (hold_cnt == HOLD_LAST) begin
          ones_nx = ones_count + (WIDTH+1)'(result);
`ifdef SWEEP_STIM_SIGNATURE_EN
          sig_nx  = sig_next(signature, result);
`endif
          if (at_last) begin
            state_nx = ST_DONE;
          end else begin
            idx_nx  = idx + (WIDTH+1)'(1);
            hold_nx = '0;
            sw_nx   = map_pat;
            pv_nx   = 1'b1;
          end
        end else begin
          hold_nx = hold_cnt + HW'(1);
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      idx        <= '0;
      hold_cnt   <= '0;
      mode_r     <= '0;
      sw         <= '0;
      pat_valid  <= 1'b0;
      ones_count <= '0;
`ifdef SWEEP_STIM_SIGNATURE_EN
      signature  <= 16'h0000;
`endif
    end else begin
      state      <= state_nx;
      idx        <= idx_nx;
      hold_cnt   <= hold_nx;
      mode_r     <= mode_nx;
      sw         <= sw_nx;
      pat_valid  <= pv_nx;
      ones_count <= ones_nx;
`ifdef SWEEP_STIM_SIGNATURE_EN
      signature  <= sig_nx;
`endif
    end
  end

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_sweep_stim_gen.sv
// tb/tb_sweep_stim_gen.sv - scoreboard bench for sweep_stim_gen with randomized sweeps
module tb_sweep_stim_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [1:0] mode = 2'd0;
  logic       result;
  logic [4:0] sw;
  logic       pat_valid, busy, done;
  logic [5:0] ones_count;
  logic       start_f = 1'b0;
  logic [4:0] sw_f;
  logic       pat_valid_f, busy_f, done_f;
  logic [5:0] ones_f;
`ifdef SWEEP_STIM_SIGNATURE_EN
  logic [15:0] sig_m, sig_f;
`endif

  logic [4:0] rmask = 5'd0;
  logic       force1 = 1'b0;
  logic [4:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  assign result = force1 | ^(sw & rmask);

  always #5 clk = ~clk;

  sweep_stim_gen #(.WIDTH(5), .HOLD_CYCLES(10)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode), .result(result),
    .sw(sw), .pat_valid(pat_valid), .busy(busy), .done(done), .ones_count(ones_count)
`ifdef SWEEP_STIM_SIGNATURE_EN
    , .signature(sig_m)
`endif
  );

  sweep_stim_gen #(.WIDTH(5), .HOLD_CYCLES(1)) u_fast (
    .clk(clk), .rst_n(rst_n), .start(start_f), .stop(1'b0), .mode(2'd0), .result(1'b1),
    .sw(sw_f), .pat_valid(pat_valid_f), .busy(busy_f), .done(done_f), .ones_count(ones_f)
`ifdef SWEEP_STIM_SIGNATURE_EN
    , .signature(sig_f)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] ref_pat(input logic [1:0] m, input int i);
    case (m)
      2'd0:    return 5'(i);
      2'd1:    return 5'(i ^ (i >> 1));
      2'd2:    return 5'(1 << i);
      default: return 5'(31 - i);
    endcase
  endfunction

  function automatic logic [15:0] crc_step(input logic [15:0] s, input logic b);
    logic [15:0] n;
    n = {s[14:0], 1'b0};
    if (s[15]) n = n ^ 16'h1021;
    n[0] = n[0] ^ b;
    return n;
  endfunction

  // Monitor: every presented pattern must be the next one the model expects.
  always @(negedge clk) begin
    if (rst_n && pat_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pat actual=%0h expected=none", sw);
      end else begin
        chk("sw_pattern", 32'(sw), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic sweep(input logic [1:0] m, input logic [4:0] rm, input logic f1,
                       input bit disturb, input bit with_stop);
    int len, ones, cycles;
    logic [15:0] sig;
    logic [4:0] p;
    logic r;
    len = (m == 2'd2) ? 5 : 32;
    ones = 0;
    sig = 16'hFFFF;
    p = '0;
    rmask = rm;
    force1 = f1;
    for (int i = 0; i < len; i++) begin
      p = ref_pat(m, i);
      exp_q.push_back(p);
      r = f1 | ^(p & rm);
      ones += int'(r);
      sig = crc_step(sig, r);
    end
    @(negedge clk);
    mode = m;
    start = 1'b1;
    stop = with_stop;
    @(negedge clk);
    start = 1'b0;
    stop = 1'b0;
    cycles = 1;
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("done_after_start", 32'(done), 32'd0);
    while (!done && cycles < 1000) begin
      start = disturb && (cycles < len * 10 - 5) && ($urandom_range(0, 7) == 0);
      if (disturb) mode = 2'($urandom);
      @(negedge clk);
      cycles++;
    end
    start = 1'b0;
    chk("sweep_cycles", 32'(cycles), 32'(len * 10 + 1));
    chk("ones_count", 32'(ones_count), 32'(ones));
    chk("busy_in_done", 32'(busy), 32'd0);
    chk("sw_last", 32'(sw), 32'(p));
    chk("patterns_left", 32'(exp_q.size()), 32'd0);
`ifdef SWEEP_STIM_SIGNATURE_EN
    chk("signature", 32'(sig_m), 32'(sig));
`endif
  endtask

  initial begin
    int n;
    logic [15:0] sig;
    #1;
    chk("rst_sw", 32'(sw), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pv", 32'(pat_valid), 32'd0);
    chk("rst_ones", 32'(ones_count), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);

    sweep(2'd0, 5'd1, 1'b0, 0, 0);
    sweep(2'd1, 5'd1, 1'b0, 0, 0);
    sweep(2'd2, 5'd0, 1'b1, 0, 0);
    sweep(2'd3, 5'($urandom), 1'b0, 0, 0);
    for (int k = 0; k < 3; k++)
      sweep(2'($urandom), 5'($urandom), 1'($urandom_range(0, 3) == 0), 1, 1'($urandom));

    // Stop (with a simultaneous start) in the last cycle of the sw=7 window.
    rmask = 5'd1;
    force1 = 1'b0;
    sig = 16'hFFFF;
    for (int i = 0; i < 8; i++) exp_q.push_back(5'(i));
    for (int i = 0; i < 7; i++) sig = crc_step(sig, 1'(i & 1));
    @(negedge clk);
    mode = 2'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(pat_valid && sw == 5'd7) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("stop_reach_7", 32'(n < 400), 32'd1);
    repeat (9) @(negedge clk);
    start = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop = 1'b0;
    chk("stop_busy", 32'(busy), 32'd0);
    chk("stop_done", 32'(done), 32'd0);
    chk("stop_sw", 32'(sw), 32'd7);
    chk("stop_ones", 32'(ones_count), 32'd3);
`ifdef SWEEP_STIM_SIGNATURE_EN
    chk("stop_signature", 32'(sig_m), 32'(sig));
`endif
    repeat (5) @(negedge clk);
    chk("stop_hold_busy", 32'(busy), 32'd0);
    chk("stop_hold_sw", 32'(sw), 32'd7);
    chk("stop_patterns_left", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset between edges while sw=12.
    for (int i = 0; i < 13; i++) exp_q.push_back(5'(i));
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(pat_valid && sw == 5'd12) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("rst_reach_12", 32'(n < 400), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_sw", 32'(sw), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_pv", 32'(pat_valid), 32'd0);
    chk("arst_ones", 32'(ones_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    repeat (4) @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_done", 32'(done), 32'd0);
    chk("post_rst_sw", 32'(sw), 32'd0);

    // HOLD_CYCLES=1 instance: new pattern on every cycle.
    sig = 16'hFFFF;
    @(negedge clk);
    start_f = 1'b1;
    @(negedge clk);
    start_f = 1'b0;
    for (int i = 0; i < 32; i++) begin
      chk("fast_pv", 32'(pat_valid_f), 32'd1);
      chk("fast_sw", 32'(sw_f), 32'(i));
      sig = crc_step(sig, 1'b1);
      @(negedge clk);
    end
    chk("fast_done", 32'(done_f), 32'd1);
    chk("fast_busy", 32'(busy_f), 32'd0);
    chk("fast_ones", 32'(ones_f), 32'd32);
    chk("fast_pv_end", 32'(pat_valid_f), 32'd0);
`ifdef SWEEP_STIM_SIGNATURE_EN
    chk("fast_signature", 32'(sig_f), 32'(sig));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
